// File: rtl/number_div_pkg.sv
// Shared types and defaults for the sequential number divider.
// Provides the FSM state enum and default datapath widths.
package number_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIVIDE,
        S_DONE
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DW    = 4;

endpackage

// File: rtl/number_divider_fsm_div_step.sv
// div_step: one combinational restoring-division step.
// Ports: rem_in (DW+1 partial remainder), bit_in (next dividend bit),
//        divisor (DW) -> rem_out (DW+1 next remainder), q (quotient bit).
module div_step #(
    parameter int DW = 4
) (
    input  logic [DW:0]   rem_in,
    input  logic          bit_in,
    input  logic [DW-1:0] divisor,
    output logic [DW:0]   rem_out,
    output logic          q
);

    logic [DW:0] shifted;
    logic [DW:0] dvs;

    assign shifted = {rem_in[DW-1:0], bit_in};
    assign dvs     = {1'b0, divisor};

    // rem_in[DW] is the bit shifted out; if set the true value already
    // exceeds any DW-bit divisor, and the DW+1-bit subtract stays exact.
    assign q       = rem_in[DW] | (shifted >= dvs);
    assign rem_out = q ? (shifted - dvs) : shifted;

endmodule

// File: rtl/number_divider_fsm.sv
// Sequential parity classifier and restoring divider, one bit per cycle.
// Ports: clk, rst (sync, active-high), start/number/divisor in;
//        ready, busy, done, result, quot, rem_val, err out.
module number_divider_fsm
    import number_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DW    = DEF_DW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] number,
    input  logic [DW-1:0]    divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic [WIDTH-1:0] quot,
    output logic [DW-1:0]    rem_val,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] dvd;
    logic [DW-1:0]    dsr;
    logic [DW:0]      prem;
    logic [CW-1:0]    cnt;
    logic [DW:0]      step_rem;
    logic             step_q;

    assign ready = (state == S_IDLE);
    assign busy  = (state == S_DIVIDE);

    div_step #(
        .DW(DW)
    ) u_step (
        .rem_in (prem),
        .bit_in (dvd[WIDTH-1]),
        .divisor(dsr),
        .rem_out(step_rem),
        .q      (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            dvd     <= '0;
            dsr     <= '0;
            prem    <= '0;
            cnt     <= '0;
            done    <= 1'b0;
            result  <= 1'b0;
            quot    <= '0;
            rem_val <= '0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        result <= number[0];
                        if (divisor == '0) begin
                            err     <= 1'b1;
                            quot    <= '1;
                            rem_val <= number[DW-1:0];
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end else begin
                            err     <= 1'b0;
                            dvd     <= number;
                            dsr     <= divisor;
                            prem    <= '0;
                            quot    <= '0;
                            rem_val <= '0;
                            cnt     <= CW'(WIDTH - 1);
                            state   <= S_DIVIDE;
                        end
                    end
                end
                S_DIVIDE: begin
                    dvd     <= {dvd[WIDTH-2:0], 1'b0};
                    prem    <= step_rem;
                    quot    <= {quot[WIDTH-2:0], step_q};
                    rem_val <= step_rem[DW-1:0];
                    cnt     <= cnt - 1'b1;
                    // Last step retires bit 0; results land as DONE is entered.
                    if (cnt == '0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_number_divider_fsm.sv
// Self-checking bench for number_divider_fsm (WIDTH=8, DW=4).
// Directed test-plan cases plus random requests against an arithmetic model.
module tb_number_divider_fsm;

    localparam int WIDTH = 8;
    localparam int DW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] number;
    logic [DW-1:0]    divisor;
    logic             ready;
    logic             busy;
    logic             done;
    logic             result;
    logic [WIDTH-1:0] quot;
    logic [DW-1:0]    rem_val;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    number_divider_fsm #(
        .WIDTH(WIDTH),
        .DW   (DW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .number (number),
        .divisor(divisor),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .result (result),
        .quot   (quot),
        .rem_val(rem_val),
        .err    (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 50) begin
            tick();
            n++;
        end
        chk("ready_timeout", 32'(ready), 32'd1);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'd0);
        chk({tag, "_quot"}, 32'(quot), 32'd0);
        chk({tag, "_rem"}, 32'(rem_val), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Issue a request, optionally poke a stray start mid-flight, then
    // compare latency, busy span, results and done width with the model.
    task automatic run_req(input string tag, input int n, input int d,
                           input int poke_at, input int poke_num);
        int lat;
        int bcnt;
        int dones;
        int eq;
        int er;
        int ee;
        eq = (d == 0) ? 255 : n / d;
        er = (d == 0) ? (n % 16) : n % d;
        ee = (d == 0) ? 1 : 0;
        wait_ready();
        start   = 1'b1;
        number  = WIDTH'(n);
        divisor = DW'(d);
        tick();
        start = 1'b0;
        lat   = 1;
        bcnt  = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (lat == poke_at) begin
                start  = 1'b1;
                number = WIDTH'(poke_num);
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'(WIDTH + 1));
        chk({tag, "_busy"}, 32'(bcnt), (d == 0) ? 32'd0 : 32'(WIDTH));
        chk({tag, "_quot"}, 32'(quot), 32'(eq));
        chk({tag, "_rem"}, 32'(rem_val), 32'(er));
        chk({tag, "_result"}, 32'(result), 32'(n % 2));
        chk({tag, "_err"}, 32'(err), 32'(ee));
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) dones++;
        end
        chk({tag, "_extra_done"}, 32'(dones), 32'd0);
        chk({tag, "_hold_quot"}, 32'(quot), 32'(eq));
    endtask

    initial begin
        int rn;
        int rd;
        int dcnt;
        rst     = 1'b1;
        start   = 1'b0;
        number  = '0;
        divisor = '0;
        tick();
        tick();
        check_reset_outs("reset");
        rst = 1'b0;
        tick();

        run_req("200_3", 200, 3, 0, 0);
        run_req("255_15", 255, 15, 0, 0);
        run_req("7_0", 7, 0, 0, 0);
        run_req("9_2", 9, 2, 0, 0);
        run_req("0_7", 0, 7, 0, 0);
        run_req("100_9_poke", 100, 9, 3, 50);

        // Reset in the middle of a division: no done may follow.
        wait_ready();
        start   = 1'b1;
        number  = 8'd201;
        divisor = 4'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outs("midrst");
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("midrst_no_done", 32'(dcnt), 32'd0);
        run_req("13_5", 13, 5, 0, 0);

        for (int i = 0; i < 20; i++) begin
            rn = int'($urandom_range(0, 255));
            rd = int'($urandom_range(0, 15));
            run_req($sformatf("rand%0d", i), rn, rd, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
